sync_fifo: RTL
==============

# sync_fifo

Single-clock, parametrised FIFO built on an inferred dual-port RAM (block or distributed), with pointer and flag control, programmable almost-full/almost-empty thresholds, occupancy count and error pulses. It is selectable between standard (registered read) and first-word-fall-through (FWFT) modes. It is the same-clock-domain companion to the async FIFO memory and is used for buffering inside a single clock domain of the TSN datapath.

## Interface
- DATA_WIDTH, 8: word width in bits.
- FIFO_DEPTH, 16: capacity in words; power of two, ≥ 4.
- FWFT, 0: 0 = standard read mode, 1 = first-word-fall-through mode.
- RAM_STYLE, 1: 1 = block RAM, 0 = distributed RAM.
- AFULL_THRESH, FIFO_DEPTH-2: almost_full_o asserts when count ≥ this value; range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 2: almost_empty_o asserts when count ≤ this value; range 0..FIFO_DEPTH-1.
- Derived, not overridable: ADDR_WIDTH = clog2s(FIFO_DEPTH); CNT_WIDTH = ADDR_WIDTH+1.
- clk_i  input  1  sole clock; all logic is on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- wr_en_i  input  1  write request.
- wr_data_i  input  DATA_WIDTH  write data.
- rd_en_i  input  1  read request. In FWFT mode this is the pop/acknowledge of rd_data_o.
- rd_data_o  output  DATA_WIDTH  read data.
- full_o  output  1  count == FIFO_DEPTH.
- almost_full_o  output  1  count ≥ AFULL_THRESH.
- empty_o  output  1  no word available to read.
- almost_empty_o  output  1  count ≤ AEMPTY_THRESH.
- data_cnt_o  output  CNT_WIDTH  words held (0..FIFO_DEPTH).
- overflow_o  output  1  one-cycle pulse: write rejected.
- underflow_o  output  1  one-cycle pulse: read rejected.

## Operation
- Acceptance is decided on the registered flags at the start of each cycle.
  - A write is accepted iff wr_en_i && !full_o.
  - A read is accepted iff rd_en_i && !empty_o.
- Rejected requests do not change any state.
  - wr_en_i && full_o pulses overflow_o high for 1 cycle.
  - rd_en_i && empty_o pulses underflow_o high for 1 cycle.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Full with rd_en_i and wr_en_i both high: only the read is accepted, count goes to FIFO_DEPTH-1, and overflow_o pulses.
- Empty with rd_en_i and wr_en_i both high: only the write is accepted, and underflow_o pulses.
- Pointers are ADDR_WIDTH bits and wrap from FIFO_DEPTH-1 to 0 with no special-casing.
- The occupancy counter is a separate CNT_WIDTH-bit register.
- All flags and data_cnt_o are registered, computed from next-state count, and therefore aligned with each other.
- Standard mode (FWFT=0):
  - rd_data_o is a register loaded from RAM only on an accepted read; otherwise it holds its value.
  - empty_o = (count == 0).
- FWFT mode (FWFT=1):
  - An output prefetch register holds the head word.
  - The head word counts toward data_cnt_o. Total capacity stays FIFO_DEPTH.
  - empty_o = 0 exactly when rd_data_o holds a valid head word.
  - On an accepted read, the next word (if any) is loaded in the same edge, so back-to-back reads give one word per cycle.
  - When the prefetch register is empty and RAM is non-empty, it self-loads without rd_en_i.
- RAM contents are not reset. The RAM is inferred with the attribute ram_style = "block" / "distributed" per RAM_STYLE.
- Reset:
  - Pointers and count go to 0, and the FWFT prefetch register is cleared (invalid).
  - Output values: rd_data_o=0, empty_o=1, almost_empty_o=1 (AEMPTY_THRESH ≥ 0), full_o=0, almost_full_o=0, data_cnt_o=0, overflow_o=0, underflow_o=0.
  - Reset asserted mid-operation discards all contents on that edge. Requests in the reset cycle are ignored and raise no error pulses.

## Timing
- Write to visible count: data_cnt_o, full_o and almost_* update on the edge that accepts the write (visible next cycle).
- Write to empty_o deassertion from empty:
  - Standard mode: 1 cycle.
  - FWFT mode: 2 cycles (RAM write, then prefetch). During the intermediate cycle data_cnt_o=1 while empty_o=1.
- Read latency:
  - Standard mode: rd_data_o is valid 1 cycle after the accepted read and stays until the next accepted read.
  - FWFT mode: 0 cycles; data is valid whenever empty_o=0 and changes on the edge after an accepted read.
- Sustained throughput: 1 write and 1 read per cycle in both modes, including at full and at empty boundaries (subject to the acceptance rules above).
- overflow_o and underflow_o are registered and asserted in the cycle after the offending request.

## Test plan
All scenarios use DATA_WIDTH=8 and FIFO_DEPTH=16 unless stated.
- Reset: hold rst_i for 2 cycles with random wr_en_i/rd_en_i -> all outputs at their reset values, no error pulses.
- Fill/drain, standard mode: write 0x00..0x0F, then 1 extra write -> full_o=1 after the 16th write, data_cnt_o=16, overflow_o pulses once. Read 17 times -> rd_data_o sequence 0x00..0x0F, each 1 cycle after its read; empty_o=1 after the 16th read; underflow_o pulses once.
- FWFT: write 0xA5 into an empty FIFO -> empty_o=0 and rd_data_o=0xA5 two cycles later. Write 0x11 and 0x22, then hold rd_en_i for 3 cycles -> 0xA5, 0x11, 0x22 on consecutive cycles, then empty_o=1.
- Thresholds with AFULL_THRESH=14, AEMPTY_THRESH=2: step count 0→16→0 -> almost_full_o high exactly for count ≥ 14; almost_empty_o high exactly for count ≤ 2.
- Simultaneous operations:
  - At count=16 with rd_en_i=wr_en_i=1 -> count=15 and overflow_o pulses.
  - At count=0 -> count=1 and underflow_o pulses.
  - At count=8 for 40 cycles -> count stays 8, pointers wrap, data order preserved.
- Reset mid-stream: assert rst_i at count=9 in FWFT mode -> next cycle empty_o=1, data_cnt_o=0. A subsequent write of 0x3C is read back as 0x3C, not stale data.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a single-clock FIFO and its user.
// The user side takes the master modport, the FIFO takes the slave modport.
interface sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) ();
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  full_o;
    logic                  almost_full_o;
    logic                  empty_o;
    logic                  almost_empty_o;
    logic [CNT_WIDTH-1:0]  data_cnt_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output wr_en_i,
        output wr_data_i,
        output rd_en_i,
        input  rd_data_o,
        input  full_o,
        input  almost_full_o,
        input  empty_o,
        input  almost_empty_o,
        input  data_cnt_o,
        input  overflow_o,
        input  underflow_o
    );

    modport slave (
        input  wr_en_i,
        input  wr_data_i,
        input  rd_en_i,
        output rd_data_o,
        output full_o,
        output almost_full_o,
        output empty_o,
        output almost_empty_o,
        output data_cnt_o,
        output overflow_o,
        output underflow_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO on an inferred dual-port RAM with registered flags, occupancy count,
// error pulses and a selectable standard / first-word-fall-through read path.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned RAM_STYLE     = 1,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    sync_fifo_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] DepthCnt  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AfullCnt  = CNT_WIDTH'(AFULL_THRESH);
    localparam logic [CNT_WIDTH-1:0] AemptyCnt = CNT_WIDTH'(AEMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, ram_rdata;
    logic                  full_q, almost_full_q, empty_q, almost_empty_q;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc, ram_we, ram_re, empty_d;

    // Acceptance uses only the registered flags, so a full FIFO never takes a same-cycle write.
    assign wr_acc = bus.wr_en_i && !full_q;
    assign rd_acc = bus.rd_en_i && !empty_q;
    assign ram_we = wr_acc && !rst_i;

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    if (RAM_STYLE != 0) begin : g_block_ram
        (* ram_style = "block" *)
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

        always_ff @(posedge clk_i) begin
            if (ram_we) begin
                mem[wr_ptr_q] <= bus.wr_data_i;
            end
        end

        assign ram_rdata = mem[rd_ptr_q];
    end else begin : g_dist_ram
        (* ram_style = "distributed" *)
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

        always_ff @(posedge clk_i) begin
            if (ram_we) begin
                mem[wr_ptr_q] <= bus.wr_data_i;
            end
        end

        assign ram_rdata = mem[rd_ptr_q];
    end

    if (FWFT != 0) begin : g_fwft
        // rd_data_q acts as the prefetch register; ram_cnt_q counts only words still in RAM.
        logic [CNT_WIDTH-1:0] ram_cnt_q, ram_cnt_d;
        logic                 valid_q, valid_d;
        logic                 load;

        always_comb begin
            load      = (!valid_q || rd_acc) && (ram_cnt_q != '0);
            valid_d   = valid_q;
            ram_cnt_d = ram_cnt_q;
            if (load) begin
                valid_d = 1'b1;
            end else if (rd_acc) begin
                valid_d = 1'b0;
            end
            if (ram_we && !load) begin
                ram_cnt_d = ram_cnt_q + 1'b1;
            end else if (!ram_we && load) begin
                ram_cnt_d = ram_cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ram_cnt_q <= '0;
                valid_q   <= 1'b0;
            end else begin
                ram_cnt_q <= ram_cnt_d;
                valid_q   <= valid_d;
            end
        end

        assign ram_re  = load;
        assign empty_d = !valid_d;
    end else begin : g_std
        assign ram_re  = rd_acc;
        assign empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_data_q      <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ram_re) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= ram_rdata;
            end
            count_q        <= count_d;
            full_q         <= (count_d == DepthCnt);
            almost_full_q  <= (count_d >= AfullCnt);
            empty_q        <= empty_d;
            almost_empty_q <= (count_d <= AemptyCnt);
            overflow_q     <= bus.wr_en_i && full_q;
            underflow_q    <= bus.rd_en_i && empty_q;
        end
    end

    assign bus.rd_data_o      = rd_data_q;
    assign bus.full_o         = full_q;
    assign bus.almost_full_o  = almost_full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_empty_o = almost_empty_q;
    assign bus.data_cnt_o     = count_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.underflow_o    = underflow_q;
endmodule
